// File: rtl/fp_pkg.sv
// fp_pkg -- shared definitions for the fp32 pack/round pipeline.
//   Rounding-mode codes, flag bit positions inside {NV, OF, UF, NX},
//   the fp32 exponent bias, canonical encodings, the result-class enum
//   carried between stages and the overflow-direction helper.
package fp_pkg;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;

  localparam int FLAG_NV = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  localparam int FP_BIAS = 127;

  localparam logic [31:0] FP_QNAN       = 32'h7FC0_0000;
  localparam logic [31:0] FP_MAX_FINITE = 32'h7F7F_FFFF;
  localparam logic [31:0] FP_INF_MAG    = 32'h7F80_0000;

  typedef enum logic [1:0] {
    CLS_NUM  = 2'd0,
    CLS_ZERO = 2'd1,
    CLS_INF  = 2'd2,
    CLS_NAN  = 2'd3
  } fp_class_e;

  // On overflow: 1 -> saturate to infinity, 0 -> clamp to max finite.
  // Reserved rounding codes follow RNE, which always goes to infinity.
  function automatic logic ovf_to_inf(input logic [2:0] rm, input logic sign);
    case (rm)
      RM_RTZ:  return 1'b0;
      RM_RDN:  return sign;
      RM_RUP:  return !sign;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/fp_round.sv
// fp_round -- combinational rounding-increment decision.
//   i_rm      rounding mode (reserved codes behave as RNE)
//   i_sign    result sign
//   i_lsb     least significant kept significand bit
//   i_guard   first bit below the LSB
//   i_round   second bit below the LSB
//   i_sticky  OR of everything further below
//   o_inc     1 when the truncated significand must be incremented
module fp_round
  import fp_pkg::*;
(
  input  logic [2:0] i_rm,
  input  logic       i_sign,
  input  logic       i_lsb,
  input  logic       i_guard,
  input  logic       i_round,
  input  logic       i_sticky,
  output logic       o_inc
);

  logic w_inexact;
  assign w_inexact = i_guard | i_round | i_sticky;

  always_comb begin
    case (i_rm)
      RM_RTZ:  o_inc = 1'b0;
      RM_RDN:  o_inc = i_sign & w_inexact;
      RM_RUP:  o_inc = !i_sign & w_inexact;
      RM_RMM:  o_inc = i_guard;
      // nearest-even: above half, or exactly half with an odd LSB
      default: o_inc = i_guard & (i_lsb | i_round | i_sticky);
    endcase
  end

endmodule

// File: rtl/fp_pack.sv
// fp_pack -- two-stage pipeline that rounds and packs a normalised
// significand / unbiased exponent into an IEEE-754 single.
//   Stage 1: bias the exponent, denormalise tiny results, classify.
//   Stage 2: round (fp_round), renormalise, overflow handling, pack.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   operand handshake
//   in_sign, in_exp       sign, signed unbiased exponent (EXP_W bits)
//   in_mant               [26] leading one, [25:3] fraction, [2:0] G/R/S
//   in_is_nan/inf/zero    special class, priority nan > inf > zero
//   in_invalid            upstream invalid flag, forwarded as NV
//   in_rm                 rounding mode
//   out_valid / out_ready result handshake
//   out_result, out_flags packed single, {NV, OF, UF, NX}
// Build option: FP_PACK_SUBNORM_EN enables gradual underflow; without it
// every tiny result flushes to signed zero with UF|NX.
module fp_pack
  import fp_pkg::*;
#(
  parameter int EXP_W = 10,
  parameter int BIAS  = FP_BIAS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_sign,
  input  logic [EXP_W-1:0] in_exp,
  input  logic [26:0]      in_mant,
  input  logic             in_is_nan,
  input  logic             in_is_inf,
  input  logic             in_is_zero,
  input  logic             in_invalid,
  input  logic [2:0]       in_rm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [3:0]       out_flags
);

  // two guard bits keep in_exp + BIAS and the post-round increment in range
  localparam int EW = EXP_W + 2;
  localparam logic [EW-1:0] E_MAX = EW'(255);

  logic            r_s1_valid;
  logic            r_s1_sign;
  logic            r_s1_inv;
  logic            r_s1_tiny;
  logic [2:0]      r_s1_rm;
  logic [EW-1:0]   r_s1_e;
  logic [26:0]     r_s1_mant;
  fp_class_e       r_s1_cls;

  logic            r_s2_valid;
  logic [31:0]     r_result;
  logic [3:0]      r_flags;

  // ---------------------------------------------------------------- handshake
  logic w_s2_take;
  logic w_s1_take;

  assign w_s2_take  = !r_s2_valid | out_ready;
  assign in_ready   = !r_s1_valid | w_s2_take;
  assign w_s1_take  = in_valid & in_ready;
  assign out_valid  = r_s2_valid;
  assign out_result = r_result;
  assign out_flags  = r_flags;

  // ---------------------------------------------------------------- stage 1
  logic signed [EW-1:0] w_e_biased;
  logic                 w_tiny;
  fp_class_e            w_cls;
  logic [EW-1:0]        w_e1;
  logic [26:0]          w_mant1;

  assign w_e_biased = $signed({{2{in_exp[EXP_W-1]}}, in_exp}) + $signed(EW'(BIAS));
  assign w_tiny     = w_e_biased[EW-1] | (w_e_biased == '0);

  // a missing leading one without a special class is a zero
  always_comb begin
    if (in_is_nan)                       w_cls = CLS_NAN;
    else if (in_is_inf)                  w_cls = CLS_INF;
    else if (in_is_zero || !in_mant[26]) w_cls = CLS_ZERO;
    else                                 w_cls = CLS_NUM;
  end

`ifdef FP_PACK_SUBNORM_EN
  localparam logic [EW-1:0] E_ONE     = EW'(1);
  localparam logic [EW-1:0] SH_LIMIT  = EW'(26);
  localparam logic [26:0]   MANT_ONES = '1;

  logic [EW-1:0] w_shamt;
  logic [26:0]   w_shifted;
  logic          w_lost;

  // only meaningful while w_tiny, where 1 - e is a positive shift
  assign w_shamt   = E_ONE - $unsigned(w_e_biased);
  assign w_shifted = in_mant >> w_shamt[4:0];
  assign w_lost    = |(in_mant & ~(MANT_ONES << w_shamt[4:0]));

  always_comb begin
    w_e1    = $unsigned(w_e_biased);
    w_mant1 = in_mant;
    if (w_tiny) begin
      w_e1 = '0;
      if (w_shamt >= SH_LIMIT) w_mant1 = {26'b0, |in_mant};
      else                     w_mant1 = {w_shifted[26:1], w_shifted[0] | w_lost};
    end
  end
`else
  always_comb begin
    w_e1    = w_tiny ? '0 : $unsigned(w_e_biased);
    w_mant1 = in_mant;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst)           r_s1_valid <= 1'b0;
    else if (in_ready) r_s1_valid <= in_valid;
  end

  always_ff @(posedge clk) begin
    if (w_s1_take) begin
      r_s1_sign <= in_sign;
      r_s1_inv  <= in_invalid;
      r_s1_tiny <= w_tiny;
      r_s1_rm   <= in_rm;
      r_s1_e    <= w_e1;
      r_s1_mant <= w_mant1;
      r_s1_cls  <= w_cls;
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic [23:0]   w_sig;
  logic          w_inc;
  logic [24:0]   w_sum;
  logic          w_carry;
  logic          w_promote;
  logic [23:0]   w_mant_rnd;
  logic [EW-1:0] w_e_fin;
  logic          w_nx;
  logic          w_of;
  logic          w_flush;
  logic [31:0]   w_res;
  logic [3:0]    w_flags;

  assign w_sig = r_s1_mant[26:3];

  fp_round u_round (
    .i_rm     (r_s1_rm),
    .i_sign   (r_s1_sign),
    .i_lsb    (w_sig[0]),
    .i_guard  (r_s1_mant[2]),
    .i_round  (r_s1_mant[1]),
    .i_sticky (r_s1_mant[0]),
    .o_inc    (w_inc)
  );

  assign w_sum      = {1'b0, w_sig} + {24'b0, w_inc};
  assign w_carry    = w_sum[24];
  // a subnormal that rounds up to 0x800000 becomes the smallest normal
  assign w_promote  = (r_s1_e == '0) & w_sum[23];
  assign w_mant_rnd = w_carry ? w_sum[24:1] : w_sum[23:0];
  assign w_e_fin    = r_s1_e + {{(EW-1){1'b0}}, w_carry} + {{(EW-1){1'b0}}, w_promote};
  assign w_nx       = |r_s1_mant[2:0];
  assign w_of       = (w_e_fin >= E_MAX);

`ifdef FP_PACK_SUBNORM_EN
  assign w_flush = 1'b0;
`else
  assign w_flush = r_s1_tiny;
`endif

  always_comb begin
    w_res            = '0;
    w_flags          = '0;
    w_flags[FLAG_NV] = r_s1_inv;
    case (r_s1_cls)
      CLS_NAN:  w_res = FP_QNAN;
      CLS_INF:  w_res = {r_s1_sign, FP_INF_MAG[30:0]};
      CLS_ZERO: w_res = {r_s1_sign, 31'b0};
      default: begin
        if (w_flush) begin
          w_res            = {r_s1_sign, 31'b0};
          w_flags[FLAG_UF] = 1'b1;
          w_flags[FLAG_NX] = 1'b1;
        end else if (w_of) begin
          w_res = ovf_to_inf(r_s1_rm, r_s1_sign) ? {r_s1_sign, FP_INF_MAG[30:0]}
                                                 : {r_s1_sign, FP_MAX_FINITE[30:0]};
          w_flags[FLAG_OF] = 1'b1;
          w_flags[FLAG_NX] = 1'b1;
        end else begin
          w_res            = {r_s1_sign, w_e_fin[7:0], w_mant_rnd[22:0]};
          w_flags[FLAG_UF] = r_s1_tiny & w_nx;
          w_flags[FLAG_NX] = w_nx;
        end
      end
    endcase
  end

  // result register only loads real data, so a stalled output stays put
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_result   <= '0;
      r_flags    <= '0;
    end else if (w_s2_take) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_result <= w_res;
        r_flags  <= w_flags;
      end
    end
  end

endmodule

// File: tb/tb_fp_pack.sv
// tb_fp_pack -- randomized and directed check of fp_pack against an
// arithmetic reference model and fixed reference vectors.
// Honours FP_PACK_SUBNORM_EN the same way as the design.
module tb_fp_pack;

  typedef struct packed {
    logic        sign;
    logic [9:0]  ex;
    logic [26:0] mant;
    logic        nan;
    logic        inf;
    logic        zero;
    logic        inv;
    logic [2:0]  rm;
  } op_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_sign = 1'b0;
  logic [9:0]  in_exp = '0;
  logic [26:0] in_mant = '0;
  logic        in_is_nan = 1'b0;
  logic        in_is_inf = 1'b0;
  logic        in_is_zero = 1'b0;
  logic        in_invalid = 1'b0;
  logic [2:0]  in_rm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_result;
  logic [3:0]  out_flags;

  fp_pack #(.EXP_W(10), .BIAS(127)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sign    (in_sign),
    .in_exp     (in_exp),
    .in_mant    (in_mant),
    .in_is_nan  (in_is_nan),
    .in_is_inf  (in_is_inf),
    .in_is_zero (in_is_zero),
    .in_invalid (in_invalid),
    .in_rm      (in_rm),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_flags  (out_flags)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  op_t         src_q[$];
  logic [35:0] src_exp_q[$];
  logic [35:0] exp_q[$];
  bit          have = 0;
  op_t         cur;
  logic [35:0] cur_exp;
  bit          last_in_ready, last_out_valid;
  bit          prev_stall = 0;
  logic [35:0] prev_out;
  int          seen_out;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, expv);
    end
  endtask

  function automatic op_t mk(input bit sign, input int ex, input logic [26:0] mant, input logic [2:0] rm);
    op_t o;
    o = '0;
    o.sign = sign;
    o.ex   = 10'(ex);
    o.mant = mant;
    o.rm   = rm;
    return o;
  endfunction

  // Reference: value-level rounding of m * 2^(e-127-26), result {flags, bits}.
  function automatic logic [35:0] model(input op_t o);
    int     e;
    longint m, q, r, p;
    bit     tiny, nx, up, to_inf;
    logic [3:0] f;
    f = {o.inv, 3'b000};
    if (o.nan)          return {f, 32'h7FC0_0000};
    if (o.inf)          return {f, o.sign, 31'h7F80_0000};
    if (o.zero || !o.mant[26]) return {f, o.sign, 31'h0};
    e = int'($signed(o.ex)) + 127;
    m = longint'(o.mant);
    tiny = (e <= 0);
    if (tiny) begin
`ifdef FP_PACK_SUBNORM_EN
      if (1 - e >= 27) m = 1;
      else begin
        p = longint'(1) << (1 - e);
        r = m % p;
        m = m / p;
        if (r != 0) m = m | 1;
      end
      e = 0;
`else
      return {o.inv, 3'b011, o.sign, 31'h0};
`endif
    end
    q  = m / 8;
    r  = m % 8;
    nx = (r != 0);
    case (o.rm)
      3'd1:    up = 0;
      3'd2:    up = nx && o.sign;
      3'd3:    up = nx && !o.sign;
      3'd4:    up = (r >= 4);
      default: up = (r > 4) || (r == 4 && (q % 2) == 1);
    endcase
    q = q + longint'(up);
    if (q == (longint'(1) << 24)) begin
      q = q / 2;
      e = e + 1;
    end
    if (e == 0 && q >= (longint'(1) << 23)) e = 1;
    if (e >= 255) begin
      to_inf = (o.rm == 3'd1) ? 1'b0 : (o.rm == 3'd2) ? o.sign : (o.rm == 3'd3) ? !o.sign : 1'b1;
      return {o.inv, 3'b101, o.sign, to_inf ? 31'h7F80_0000 : 31'h7F7F_FFFF};
    end
    return {o.inv, 1'b0, tiny && nx, nx, o.sign, 8'(e), 23'(q)};
  endfunction

  function automatic op_t rand_op();
    op_t o;
    int  sel, ex;
    o      = '0;
    o.sign = 1'($urandom_range(1));
    sel    = int'($urandom_range(99));
    if (sel < 10)      ex = int'($urandom_range(1023)) - 512;
    else if (sel < 40) ex = int'($urandom_range(40)) - 150;
    else if (sel < 60) ex = int'($urandom_range(10)) + 122;
    else               ex = int'($urandom_range(200)) - 100;
    o.ex = 10'(ex);
    if ($urandom_range(9) == 0) o.mant = {1'b1, 23'h7FFFFF, 3'($urandom)};
    else                        o.mant = {($urandom_range(19) != 0), 26'($urandom)};
    o.nan  = ($urandom_range(24) == 0);
    o.inf  = ($urandom_range(19) == 0);
    o.zero = ($urandom_range(19) == 0);
    o.inv  = ($urandom_range(9) == 0);
    o.rm   = 3'($urandom_range(7));
    return o;
  endfunction

  task automatic drive(input bit v, input op_t o);
    in_valid   = v;
    in_sign    = o.sign;
    in_exp     = o.ex;
    in_mant    = o.mant;
    in_is_nan  = o.nan;
    in_is_inf  = o.inf;
    in_is_zero = o.zero;
    in_invalid = o.inv;
    in_rm      = o.rm;
  endtask

  task automatic push(input op_t o, input logic [35:0] e);
    src_q.push_back(o);
    src_exp_q.push_back(e);
  endtask

  task automatic step(input bit rdy);
    logic [35:0] e;
    @(negedge clk);
    if (!have && src_q.size() > 0) begin
      cur     = src_q.pop_front();
      cur_exp = src_exp_q.pop_front();
      have    = 1;
    end
    drive(have, cur);
    out_ready = rdy;
    #1;
    if (prev_stall) check("hold", {out_valid, out_flags, out_result}, {1'b1, prev_out});
    prev_stall = out_valid && !out_ready;
    prev_out   = {out_flags, out_result};
    if (out_valid) seen_out++;
    if (out_valid && out_ready) begin
      check("expected_pending", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("result", out_result, e[31:0]);
        check("flags", out_flags, e[35:32]);
      end
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(cur_exp);
      have = 0;
    end
    last_in_ready  = in_ready;
    last_out_valid = out_valid;
  endtask

  task automatic run(input int pct, input int budget, output int cyc);
    cyc = 0;
    while ((have || src_q.size() > 0 || exp_q.size() > 0) && cyc < budget) begin
      step($urandom_range(99) < pct);
      cyc++;
    end
    check("drain", src_q.size() + exp_q.size() + int'(have), 0);
  endtask

  initial begin
    int  lat, cyc;
    op_t o;

    // reset values
    repeat (3) @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", out_result, 0);
    check("rst_flags", out_flags, 0);
    rst = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);

    // latency with out_ready held high
    @(negedge clk);
    drive(1, mk(0, 0, 27'h4000000, 3'd0));
    out_ready = 1'b1;
    #1;
    check("lat_in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      #1;
      lat++;
    end
    check("latency", lat, 2);
    check("lat_result", out_result, 32'h3F80_0000);
    check("lat_flags", out_flags, 4'b0000);

    // fixed reference vectors
    push(mk(0, 0, {1'b1, 23'h7FFFFF, 3'b100}, 3'd0), {4'b0001, 32'h4000_0000});
    push(mk(0, 128, 27'h4000000, 3'd0), {4'b0101, 32'h7F80_0000});
    push(mk(0, 128, 27'h4000000, 3'd1), {4'b0101, 32'h7F7F_FFFF});
    push(mk(1, 128, 27'h4000000, 3'd2), {4'b0101, 32'hFF80_0000});
    push(mk(0, 128, 27'h4000000, 3'd3), {4'b0101, 32'h7F80_0000});
    push(mk(0, 128, 27'h4000000, 3'd2), {4'b0101, 32'h7F7F_FFFF});
    push(mk(0, -126, 27'h4000000, 3'd0), {4'b0000, 32'h0080_0000});
`ifdef FP_PACK_SUBNORM_EN
    push(mk(0, -127, 27'h4000000, 3'd0), {4'b0000, 32'h0040_0000});
`else
    push(mk(0, -127, 27'h4000000, 3'd0), {4'b0011, 32'h0000_0000});
`endif
    o = mk(0, 5, 27'h4000000, 3'd0); o.nan = 1; o.inv = 1;
    push(o, {4'b1000, 32'h7FC0_0000});
    o = mk(1, 5, 27'h4000000, 3'd0); o.inf = 1;
    push(o, {4'b0000, 32'hFF80_0000});
    push(mk(1, 3, 27'h0123456, 3'd0), {4'b0000, 32'h8000_0000});
    run(100, 100, cyc);

    // full-rate throughput
    for (int i = 0; i < 20; i++) begin
      o = rand_op();
      push(o, model(o));
    end
    run(100, 100, cyc);
    check("throughput", cyc, 22);

    // backpressure: three back-to-back, out_ready low for three cycles
    for (int i = 0; i < 3; i++) begin
      o = rand_op();
      push(o, model(o));
    end
    step(0);
    step(0);
    step(0);
    check("stall_in_ready", last_in_ready, 0);
    check("stall_out_valid", last_out_valid, 1);
    check("stall_pending", have, 1);
    run(100, 50, cyc);

    // randomized stream with random backpressure
    for (int i = 0; i < 600; i++) begin
      o = rand_op();
      push(o, model(o));
    end
    run(70, 5000, cyc);

    // reset in the middle of a stream
    for (int i = 0; i < 4; i++) begin
      o = rand_op();
      push(o, model(o));
    end
    step(1);
    step(1);
    step(1);
    @(negedge clk);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    check("midrst_out_valid", out_valid, 0);
    src_q.delete();
    src_exp_q.delete();
    exp_q.delete();
    have = 0;
    prev_stall = 0;
    rst = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 1);
    seen_out = 0;
    for (int i = 0; i < 6; i++) step(1);
    check("post_rst_quiet", seen_out, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
